// File: rtl/fpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_bus_sequencer
// Brief    : Writes one operand pair and opcode to the 8-bit FPU bus, waits
//            for cmd_end, reads the 32-bit result back and returns it.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_bus_sequencer #(
  parameter int STROBE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_unary,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [3:0]  fpu_addr,
  output logic [7:0]  fpu_wdata,
  input  logic [7:0]  fpu_rdata,
  output logic        fpu_cs,
  output logic        fpu_wr,
  output logic        fpu_rd,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      c_STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD, ST_WAIT_END,
    ST_RD_SETUP, ST_RD_STROBE, ST_ACK, ST_ACK_DROP, ST_RESP
  } state_t;

  state_t          r_state, w_state;
  logic [7:0]      r_op;
  logic [31:0]     r_a, r_b;
  logic            r_unary;
  logic [3:0]      r_idx, w_idx;
  logic [3:0]      r_stb, w_stb;
  logic [c_TW-1:0] r_timer, w_timer;
  logic            r_cmd_end_q;
  logic [31:0]     w_result;
  logic            w_timeout, w_latch;
  logic [3:0]      w_addr;
  logic [7:0]      w_wdata;
  logic [71:0]     w_bytes;
  logic            w_cs, w_wr, w_rd, w_ack, w_req_ready, w_rsp_valid;
  logic            w_rise;
  logic [1:0]      w_rbyte;
  logic            w_unused_busy;

  // Busy is informational only; sequencing relies solely on cmd_end.
  assign w_unused_busy = fpu_busy;
  assign w_rise        = fpu_cmd_end & ~r_cmd_end_q;
  assign w_rbyte       = 2'(r_idx - 4'd9);

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_stb     = r_stb;
    w_timer   = r_timer;
    w_result  = rsp_result;
    w_timeout = rsp_timeout;
    w_latch   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          w_latch   = 1'b1;
          w_idx     = 4'd0;
          w_result  = 32'd0;
          w_timeout = 1'b0;
          w_state   = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP: begin
        w_stb   = 4'd0;
        w_state = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (r_stb == c_STB_LAST) w_state = ST_WR_HOLD;
        else                     w_stb   = r_stb + 4'd1;
      end
      ST_WR_HOLD: begin
        if (r_idx == 4'd8) begin
          w_timer = '0;
          w_state = ST_WAIT_END;
        end else begin
          w_idx   = (r_idx == 4'd3 && r_unary) ? 4'd8 : r_idx + 4'd1;
          w_state = ST_WR_SETUP;
        end
      end
      ST_WAIT_END: begin
        if (w_rise) begin
          w_idx   = 4'd9;
          w_state = ST_RD_SETUP;
        end else if (r_timer == c_TO_LAST) begin
          w_timeout = 1'b1;
          w_result  = 32'd0;
          w_state   = ST_RESP;
        end else begin
          w_timer = r_timer + c_TW'(1);
        end
      end
      ST_RD_SETUP: begin
        w_stb   = 4'd0;
        w_state = ST_RD_STROBE;
      end
      ST_RD_STROBE: begin
        if (r_stb == c_STB_LAST) begin
          w_result[{w_rbyte, 3'b000} +: 8] = fpu_rdata;
          if (r_idx == 4'd12) begin
            w_timer = '0;
            w_state = ST_ACK;
          end else begin
            w_idx   = r_idx + 4'd1;
            w_state = ST_RD_SETUP;
          end
        end else begin
          w_stb = r_stb + 4'd1;
        end
      end
      ST_ACK: begin
        w_timer = r_timer + c_TW'(1);
        w_state = ST_ACK_DROP;
      end
      ST_ACK_DROP: begin
        if (!fpu_cmd_end) begin
          w_state = ST_RESP;
        end else if (r_timer == c_TO_LAST) begin
          w_timeout = 1'b1;
          w_state   = ST_RESP;
        end else begin
          w_timer = r_timer + c_TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase

    // Bus outputs are registered from the next state so they never glitch.
    w_bytes     = w_latch ? {req_op, req_b, req_a} : {r_op, r_b, r_a};
    w_addr      = fpu_addr;
    w_wdata     = fpu_wdata;
    if (w_state == ST_WR_SETUP) begin
      w_addr  = w_idx;
      w_wdata = w_bytes[{w_idx, 3'b000} +: 8];
    end else if (w_state == ST_RD_SETUP) begin
      w_addr  = w_idx;
    end
    w_cs        = !(w_state inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD,
                                    ST_RD_SETUP, ST_RD_STROBE});
    w_wr        = (w_state != ST_WR_STROBE);
    w_rd        = (w_state != ST_RD_STROBE);
    w_ack       = (w_state inside {ST_ACK, ST_ACK_DROP});
    w_req_ready = (w_state == ST_IDLE);
    w_rsp_valid = (w_state == ST_RESP);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state     <= ST_IDLE;
      r_op        <= 8'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_unary     <= 1'b0;
      r_idx       <= 4'd0;
      r_stb       <= 4'd0;
      r_timer     <= '0;
      r_cmd_end_q <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_timeout <= 1'b0;
      fpu_addr    <= 4'd0;
      fpu_wdata   <= 8'd0;
      fpu_cs      <= 1'b1;
      fpu_wr      <= 1'b1;
      fpu_rd      <= 1'b1;
      fpu_end_ack <= 1'b0;
    end else begin
      r_state     <= w_state;
      if (w_latch) begin
        r_op    <= req_op;
        r_a     <= req_a;
        r_b     <= req_b;
        r_unary <= req_unary;
      end
      r_idx       <= w_idx;
      r_stb       <= w_stb;
      r_timer     <= w_timer;
      r_cmd_end_q <= fpu_cmd_end;
      req_ready   <= w_req_ready;
      rsp_valid   <= w_rsp_valid;
      rsp_result  <= w_result;
      rsp_timeout <= w_timeout;
      fpu_addr    <= w_addr;
      fpu_wdata   <= w_wdata;
      fpu_cs      <= w_cs;
      fpu_wr      <= w_wr;
      fpu_rd      <= w_rd;
      fpu_end_ack <= w_ack;
    end
  end

endmodule
`default_nettype wire
